// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU/LSU result streams and the registered write triple
// feeding the register file's single write port.
interface wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic                       alu_valid;
  logic [4:0]                 alu_waddr;
  logic [DATA_W-1:0]          alu_wdata;
  logic                       lsu_valid;
  logic                       lsu_ready;
  logic [4:0]                 lsu_waddr;
  logic [DATA_W-1:0]          lsu_wdata;
  logic                       reg_write;
  logic [4:0]                 waddr;
  logic [DATA_W-1:0]          wdata;
  logic [$clog2(DEPTH):0]     fifo_count;

  // Producer side: execution units plus the register file observing the triple.
  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    input  lsu_ready, reg_write, waddr, wdata, fifo_count
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    output lsu_ready, reg_write, waddr, wdata, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, colliding LSU results queue in a small
// FIFO, and younger ALU writes cancel buffered LSU writes to the same register.
module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         arst,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              fifo_valid [DEPTH];
  logic [4:0]        fifo_waddr [DEPTH];
  logic [DATA_W-1:0] fifo_wdata [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic alu_act;
  logic lsu_acc;
  logic lsu_nz;
  logic fifo_empty;
  logic do_pop;
  logic do_bypass;
  logic do_push;
  logic push_valid;

  assign bus.lsu_ready  = (count < CW'(DEPTH));
  assign bus.fifo_count = count;

  assign alu_act    = bus.alu_valid && (bus.alu_waddr != 5'd0);
  assign lsu_acc    = bus.lsu_valid && bus.lsu_ready;
  assign lsu_nz     = (bus.lsu_waddr != 5'd0);
  assign fifo_empty = (count == '0);

  assign do_pop     = !alu_act && !fifo_empty;
  assign do_bypass  = !alu_act && fifo_empty && lsu_acc && lsu_nz;
  assign do_push    = lsu_acc && lsu_nz && !do_bypass;
  // A same-cycle ALU write to the same register is younger, so the LSU entry is born dead.
  assign push_valid = !(alu_act && (bus.alu_waddr == bus.lsu_waddr));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_valid[i] <= 1'b0;
        fifo_waddr[i] <= 5'd0;
        fifo_wdata[i] <= '0;
      end
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bus.reg_write <= 1'b0;
      bus.waddr     <= 5'd0;
      bus.wdata     <= '0;
    end else begin
      // Kill stale entries first; a push to the tail below overrides its own slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_act && (fifo_waddr[i] == bus.alu_waddr)) begin
          fifo_valid[i] <= 1'b0;
        end
      end

      if (do_push) begin
        fifo_valid[wr_ptr] <= push_valid;
        fifo_waddr[wr_ptr] <= bus.lsu_waddr;
        fifo_wdata[wr_ptr] <= bus.lsu_wdata;
        wr_ptr             <= wr_ptr + PW'(1);
      end

      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (alu_act) begin
        bus.reg_write <= 1'b1;
        bus.waddr     <= bus.alu_waddr;
        bus.wdata     <= bus.alu_wdata;
      end else if (do_pop) begin
        bus.reg_write <= fifo_valid[rd_ptr];
        bus.waddr     <= fifo_waddr[rd_ptr];
        bus.wdata     <= fifo_wdata[rd_ptr];
      end else if (do_bypass) begin
        bus.reg_write <= 1'b1;
        bus.waddr     <= bus.lsu_waddr;
        bus.wdata     <= bus.lsu_wdata;
      end else begin
        bus.reg_write <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter, scored against a queue-based
// model of the writeback ordering rules.
module tb_wb_arbiter;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  typedef struct {
    bit          valid;
    logic [4:0]  addr;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic arst;

  wb_arbiter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  logic        exp_rw;
  logic [4:0]  exp_waddr;
  logic [15:0] exp_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge: drive one cycle of inputs, predict, then check.
  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [15:0] ad,
                               input logic lv, input logic [4:0] la, input logic [15:0] ld);
    bit   act, acc, byp;
    ent_t h;
    ent_t e;
    checkOutput("lsu_ready", bus.lsu_ready, (q.size() < DEPTH));
    checkOutput("count_pre", bus.fifo_count, q.size());
    bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_wdata = ad;
    bus.lsu_valid = lv; bus.lsu_waddr = la; bus.lsu_wdata = ld;

    act = av && (aa != 0);
    acc = lv && (q.size() < DEPTH);
    byp = 1'b0;
    if (act) begin
      exp_rw = 1'b1; exp_waddr = aa; exp_wdata = ad;
      foreach (q[i]) if (q[i].addr == aa) q[i].valid = 1'b0;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      exp_rw = h.valid; exp_waddr = h.addr; exp_wdata = h.data;
    end else if (acc && la != 0) begin
      byp = 1'b1;
      exp_rw = 1'b1; exp_waddr = la; exp_wdata = ld;
    end else begin
      exp_rw = 1'b0;
    end
    if (acc && la != 0 && !byp) begin
      e.valid = !(act && aa == la);
      e.addr  = la;
      e.data  = ld;
      q.push_back(e);
    end

    @(negedge clk);
    checkOutput("reg_write", bus.reg_write, exp_rw);
    checkOutput("waddr", bus.waddr, exp_waddr);
    checkOutput("wdata", bus.wdata, exp_wdata);
    checkOutput("fifo_count", bus.fifo_count, q.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
  endtask

  initial begin
    arst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_waddr = 5'd0; bus.alu_wdata = '0;
    bus.lsu_valid = 1'b0; bus.lsu_waddr = 5'd0; bus.lsu_wdata = '0;
    exp_rw = 1'b0; exp_waddr = 5'd0; exp_wdata = 16'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_reg_write", bus.reg_write, 0);
    checkOutput("rst_waddr", bus.waddr, 0);
    checkOutput("rst_wdata", bus.wdata, 0);
    checkOutput("rst_count", bus.fifo_count, 0);
    checkOutput("rst_ready", bus.lsu_ready, 1);
    arst = 1'b0;

    // ALU only
    applyStimulus(1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0);
    checkOutput("alu_waddr", bus.waddr, 3);
    checkOutput("alu_wdata", bus.wdata, 16'h1234);
    idle(1);
    checkOutput("alu_idle", bus.reg_write, 0);

    // Collision
    applyStimulus(1'b1, 5'd4, 16'hAAAA, 1'b1, 5'd5, 16'h5555);
    checkOutput("coll_waddr", bus.waddr, 4);
    checkOutput("coll_count", bus.fifo_count, 1);
    idle(1);
    checkOutput("coll_pop", bus.wdata, 16'h5555);
    checkOutput("coll_empty", bus.fifo_count, 0);

    // Full FIFO
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 5'd1, 16'h0100 + 16'(i), 1'b1, 5'(8 + i), 16'h0800 + 16'(i));
    checkOutput("full_count", bus.fifo_count, 4);
    checkOutput("full_ready", bus.lsu_ready, 0);
    idle(1);
    checkOutput("drain_first", bus.waddr, 8);
    checkOutput("drain_ready", bus.lsu_ready, 1);
    idle(3);
    checkOutput("drain_last", bus.wdata, 16'h0803);

    // WAW kill
    applyStimulus(1'b1, 5'd1, 16'h0011, 1'b1, 5'd7, 16'h0001);
    applyStimulus(1'b1, 5'd7, 16'h0002, 1'b0, 5'd0, 16'h0);
    checkOutput("waw_alu", bus.wdata, 16'h0002);
    idle(1);
    checkOutput("waw_bubble", bus.reg_write, 0);
    applyStimulus(1'b1, 5'd7, 16'h0003, 1'b1, 5'd7, 16'h0004);
    checkOutput("waw_same", bus.wdata, 16'h0003);
    idle(1);
    checkOutput("waw_same_bubble", bus.reg_write, 0);

    // x0 handling
    applyStimulus(1'b1, 5'd0, 16'hDEAD, 1'b1, 5'd2, 16'h00FF);
    checkOutput("x0_bypass", bus.waddr, 2);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd0, 16'hBEEF);
    checkOutput("x0_lsu_count", bus.fifo_count, 0);
    checkOutput("x0_lsu_write", bus.reg_write, 0);

    // Reset with three buffered entries
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 5'd1, 16'h0, 1'b1, 5'(20 + i), 16'h00C0 + 16'(i));
    checkOutput("pre_rst_count", bus.fifo_count, 3);
    arst = 1'b1;
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    #1;
    checkOutput("arst_reg_write", bus.reg_write, 0);
    checkOutput("arst_count", bus.fifo_count, 0);
    checkOutput("arst_ready", bus.lsu_ready, 1);
    q.delete();
    exp_rw = 1'b0; exp_waddr = 5'd0; exp_wdata = 16'h0;
    @(negedge clk);
    arst = 1'b0;
    idle(3);

    // Randomized traffic over a small register range to provoke collisions
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), 16'($urandom),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), 16'($urandom));
    idle(DEPTH + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
